// File: rtl/mul_uint8_arbiter_pkg.sv
// Shared constants and width helpers for the arbitrated 8-bit multiplier.
package mul_uint8_arbiter_pkg;

   localparam int MUL_W       = 8;
   localparam int PROD_W      = 2 * MUL_W;
   localparam int DEF_N_REQ   = 4;
   localparam int DEF_LATENCY = 3;

   // Requester tag width; a single requester still needs one bit to carry.
   function automatic int tag_w(input int n_req);
      return (n_req > 1) ? $clog2(n_req) : 1;
   endfunction

   // Width of a counter that must reach LATENCY inclusive.
   function automatic int cnt_w(input int latency);
      return $clog2(latency + 1);
   endfunction

   localparam int DEF_TAG_W = tag_w(DEF_N_REQ);

endpackage

// File: rtl/mul_uint8_pipe.sv
// LATENCY-stage multiplier pipeline: valid and tag travel beside the operands,
// the full product is formed on entry and only its low byte reaches the output.
module mul_uint8_pipe
   import mul_uint8_arbiter_pkg::*;
#(
   parameter int LATENCY = DEF_LATENCY,
   parameter int TAG_W   = DEF_TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [TAG_W-1:0] in_id,
   input  logic [MUL_W-1:0] in_a,
   input  logic [MUL_W-1:0] in_b,
   output logic             out_valid,
   output logic [TAG_W-1:0] out_id,
   output logic [MUL_W-1:0] out_data
);

   logic [LATENCY-1:0] valid_q;
   logic [TAG_W-1:0]   id_q [LATENCY];
   logic [PROD_W-1:0]  prod_full;
   logic [MUL_W-1:0]   data_d;
   logic [MUL_W-1:0]   data_q;

   assign prod_full = PROD_W'(in_a) * PROD_W'(in_b);

   // Valid/tag shift register; reset empties every stage so nothing in flight survives.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < LATENCY; i++) id_q[i] <= '0;
      end else begin
         valid_q[0] <= in_valid;
         id_q[0]    <= in_id;
         for (int i = 1; i < LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
            id_q[i]    <= id_q[i-1];
         end
      end
   end

   if (LATENCY == 1) begin : g_one_stage
      logic [MUL_W-1:0] unused_prod_hi;
      assign unused_prod_hi = prod_full[PROD_W-1:MUL_W];
      assign data_d         = prod_full[MUL_W-1:0];
   end else begin : g_multi_stage
      logic [PROD_W-1:0] prod_q [LATENCY-1];
      logic [MUL_W-1:0]  unused_prod_hi;

      // Full 16-bit product captured in the first stage, then carried through the middle stages.
      // NOTE: data registers carry no reset; the valid bits qualify them, so only the valids are cleared.
      always_ff @(posedge clk) begin
         prod_q[0] <= prod_full;
         for (int i = 1; i < LATENCY - 1; i++) prod_q[i] <= prod_q[i-1];
      end

      assign unused_prod_hi = prod_q[LATENCY-2][PROD_W-1:MUL_W];
      assign data_d         = prod_q[LATENCY-2][MUL_W-1:0];
   end

   // Output register holds only the truncated low byte of the product.
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign out_valid = valid_q[LATENCY-1];
   assign out_id    = out_valid ? id_q[LATENCY-1] : '0;
   assign out_data  = out_valid ? data_q : '0;

endmodule

// File: rtl/mul_uint8_arbiter.sv
// Round-robin arbiter sharing one pipelined 8-bit multiplier among N_REQ requesters,
// with a count of accepted requests whose results have not yet been presented.
module mul_uint8_arbiter
   import mul_uint8_arbiter_pkg::*;
#(
   parameter int  N_REQ   = DEF_N_REQ,
   parameter int  LATENCY = DEF_LATENCY,
   localparam int TAG_W   = tag_w(N_REQ),
   localparam int CNT_W   = cnt_w(LATENCY)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [MUL_W*N_REQ-1:0] req_a,
   input  logic [MUL_W*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   out_valid,
   output logic [TAG_W-1:0]       out_id,
   output logic [MUL_W-1:0]       out_data,
   output logic [CNT_W-1:0]       in_flight
);

   logic [TAG_W-1:0] ptr_q;
   logic [TAG_W-1:0] ptr_next;
   logic [TAG_W-1:0] grant_idx;
   logic             grant_found;
   logic [TAG_W:0]   scan;
   logic [MUL_W-1:0] sel_a;
   logic [MUL_W-1:0] sel_b;
   logic [CNT_W-1:0] in_flight_q;

   // Round-robin search from the priority pointer; the first valid requester wins.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      grant_found = 1'b0;
      grant_idx   = '0;
      scan        = '0;
      req_ready   = '0;
      if (en && !rst) begin
         for (int k = 0; k < N_REQ; k++) begin
            scan = {1'b0, ptr_q} + (TAG_W+1)'(k);
            if (scan >= (TAG_W+1)'(N_REQ)) scan = scan - (TAG_W+1)'(N_REQ);
            if (!grant_found && req_valid[scan[TAG_W-1:0]]) begin
               grant_found = 1'b1;
               grant_idx   = scan[TAG_W-1:0];
            end
         end
      end
      if (grant_found) req_ready[grant_idx] = 1'b1;
   end

   // Steer the granted requester's operands into the shared multiplier.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_idx == TAG_W'(i)) begin
            sel_a = req_a[i*MUL_W +: MUL_W];
            sel_b = req_b[i*MUL_W +: MUL_W];
         end
      end
   end

   assign ptr_next = (grant_idx == TAG_W'(N_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);

   // Priority pointer moves just past the winner and holds when nothing is granted.
   // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)              ptr_q <= '0;
      else if (grant_found) ptr_q <= ptr_next;
   end

   // Outstanding-request count: up on a handshake, down on a result, unchanged on both.
   always_ff @(posedge clk) begin
      if (rst)                            in_flight_q <= '0;
      else if (grant_found && !out_valid) in_flight_q <= in_flight_q + CNT_W'(1);
      else if (!grant_found && out_valid) in_flight_q <= in_flight_q - CNT_W'(1);
   end

   assign in_flight = in_flight_q;

   mul_uint8_pipe #(
      .LATENCY (LATENCY),
      .TAG_W   (TAG_W)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (grant_found),
      .in_id     (grant_idx),
      .in_a      (sel_a),
      .in_b      (sel_b),
      .out_valid (out_valid),
      .out_id    (out_id),
      .out_data  (out_data)
   );

endmodule

// File: doc/mul_uint8_arbiter.md
MUL_UINT8_ARBITER -- requirements
Module: mul_uint8_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one 8-bit multiplier.
REQ-002 Parameter LATENCY, default 3, cycles from accepted request to result.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  grant enable; low blocks new grants while the pipeline drains.
REQ-006 req_valid  input  N_REQ  per-requester request valid.
REQ-007 req_a  input  8*N_REQ  operand A, requester i in bits [8i+7:8i].
REQ-008 req_b  input  8*N_REQ  operand B, same packing as req_a.
REQ-009 req_ready  output  N_REQ  grant; one-hot or zero; handshake = req_valid[i] & req_ready[i].
REQ-010 out_valid  output  1  result valid, one-cycle pulse per accepted request.
REQ-011 out_id  output  clog2(N_REQ)  index of the requester owning out_data.
REQ-012 out_data  output  8  product.
REQ-013 in_flight  output  clog2(LATENCY+1)  count of accepted requests not yet output.

Function
REQ-014 req_ready SHALL be combinational from req_valid, en, rst and the priority pointer.
REQ-015 With en=1 and rst=0, exactly one valid requester SHALL be granted per cycle; with no valid requester, req_ready=0.
REQ-016 Arbitration SHALL be round-robin: search starts at the priority pointer; after a grant to i, the pointer becomes (i+1) mod N_REQ; with no grant, the pointer holds.
REQ-017 req_ready SHALL be 0 for all requesters when en=0 or rst=1; the pipeline keeps advancing.
REQ-018 An accepted request at edge T SHALL produce out_valid=1 exactly LATENCY edges later (visible after edge T+LATENCY); there is no output backpressure.
REQ-019 out_data SHALL equal (a*b) mod 256, i.e. the low 8 bits of the 16-bit product.
REQ-020 out_id SHALL equal the index of the accepted requester; the tag travels with the operands through every stage.
REQ-021 Throughput SHALL be one request per cycle; back-to-back results from consecutive grants appear on consecutive cycles.
REQ-022 When out_valid=0, out_data and out_id SHALL be 0.
REQ-023 in_flight SHALL increment on a handshake, decrement on out_valid, and hold when both occur in the same cycle; its maximum value is LATENCY.
REQ-024 Requester-side rule: req_a, req_b and req_valid held stable until handshake; dropping req_valid before grant is permitted and withdraws the request.

Reset
REQ-025 On rst=1 at an edge: priority pointer SHALL be 0, all stage valids 0, out_valid 0, out_id 0, out_data 0, in_flight 0.
REQ-026 Reset mid-operation SHALL discard all in-flight results; no out_valid may appear for requests accepted before reset.
REQ-027 The first cycle after reset SHALL grant the lowest-index valid requester.

Structure
REQ-028 Shared package SHALL hold MUL_W=8, the default N_REQ and LATENCY, and the tag width function/constant.
REQ-029 One sub-module, mul_uint8_pipe, SHALL implement the LATENCY-stage valid/tag/product pipeline with synchronous reset; the arbiter and in_flight counter live in the top.
REQ-030 The 16-bit product SHALL be formed in the first stage and truncated to 8 bits before output registering.

Verification
REQ-031 Single request: after reset, req_valid=0001, a=7, b=6 -> req_ready=0001 that cycle; out_valid, out_id=0, out_data=42 exactly 3 cycles later.
REQ-032 Truncation: a=255, b=255 -> out_data=1; a=16, b=16 -> out_data=0.
REQ-033 Fairness: all four requesters held valid for 8 cycles -> grants in order 0,1,2,3,0,1,2,3; results on 8 consecutive cycles with matching out_id.
REQ-034 Enable gating: en=0 with req_valid=1111 -> req_ready=0000; outstanding results still emerge; in_flight decrements to 0.
REQ-035 Mid-flight reset: grant 3 requests, assert rst on the next edge -> no out_valid within the following 4 cycles; in_flight=0; next grant goes to requester 0.
REQ-036 Pointer hold: grant 2, then idle for 3 cycles, then req_valid=1111 -> requester 3 granted first.
